// File: rtl/object_draw_pkg.sv
// object_draw_pkg: shared state encoding and default widths for the
// object_draw pixel-scan engine.
package object_draw_pkg;

    localparam int COLOR_W_DEF = 3;
    localparam int XSZ_DEF     = 3;
    localparam int YSZ_DEF     = 3;
    localparam int NX_DEF      = 8;
    localparam int NY_DEF      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/object_draw_xy_counter.sv
// xy_counter: W-bit pixel offset counter with synchronous clear, count
// enable and a terminal-count flag (all ones).
module xy_counter #(
    parameter int W = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Offset register: clear wins over enable, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (clear) begin
            count <= {W{1'b0}};
        end else if (enable) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end

    assign tc = (count == {W{1'b1}});

endmodule

// File: rtl/object_draw.sv
// object_draw: scans an object ROM in row-major order and emits one pixel
// write per cycle at the latched screen position. Erase mode substitutes
// a background colour. Optional macro OBJECT_DRAW_TRANSPARENT_EN suppresses
// writes of pixels whose ROM colour equals TRANSPARENT.
module object_draw
    import object_draw_pkg::*;
#(
    parameter int n           = COLOR_W_DEF,
    parameter int XSZ         = XSZ_DEF,
    parameter int YSZ         = YSZ_DEF,
    parameter int Mn          = XSZ + YSZ,
    parameter int nX          = NX_DEF,
    parameter int nY          = NY_DEF,
    parameter int TRANSPARENT = 0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          erase,
    input  logic [nX-1:0] x0,
    input  logic [nY-1:0] y0,
    input  logic [n-1:0]  bg_color,
    output logic          busy,
    output logic          done,
    output logic [Mn-1:0] rom_addr,
    input  logic [n-1:0]  rom_q,
    output logic [nX-1:0] vga_x,
    output logic [nY-1:0] vga_y,
    output logic [n-1:0]  vga_color,
    output logic          vga_write
);

    draw_state_t   state;
    draw_state_t   next_state;
    logic          cnt_clear;
    logic          cnt_en;
    logic          cnt_tc;
    logic [Mn-1:0] cnt;

    logic [nX-1:0] x0_l;
    logic [nY-1:0] y0_l;
    logic          erase_l;
    logic [n-1:0]  bg_color_l;

    logic          valid_d;
    logic [XSZ-1:0] xoff_d;
    logic [YSZ-1:0] yoff_d;

    xy_counter #(.W(Mn)) u_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cnt),
        .tc     (cnt_tc)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start only matters in IDLE; DRAW ends on terminal count.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DRAW; else next_state = IDLE;
            DRAW:    if (cnt_tc) next_state = FLUSH; else next_state = DRAW;
            FLUSH:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State-decoded controls: counter clear/enable and status outputs.
    always_comb begin
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cnt_clear = start;
            end
            DRAW:    cnt_en = ~cnt_tc;
            FLUSH:   cnt_en = 1'b0;
            DONE:    done   = 1'b1;
            default: busy   = 1'b0;
        endcase
    end

    // Capture object position and mode when a draw is accepted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0_l       <= {nX{1'b0}};
            y0_l       <= {nY{1'b0}};
            erase_l    <= 1'b0;
            bg_color_l <= {n{1'b0}};
        end else if ((state == IDLE) && start) begin
            x0_l       <= x0;
            y0_l       <= y0;
            erase_l    <= erase;
            bg_color_l <= bg_color;
        end else begin
            x0_l       <= x0_l;
            y0_l       <= y0_l;
            erase_l    <= erase_l;
            bg_color_l <= bg_color_l;
        end
    end

    // Delay the issued address by one cycle to line up with ROM data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_d <= 1'b0;
            xoff_d  <= {XSZ{1'b0}};
            yoff_d  <= {YSZ{1'b0}};
        end else begin
            valid_d <= (state == DRAW);
            xoff_d  <= cnt[XSZ-1:0];
            yoff_d  <= cnt[Mn-1:XSZ];
        end
    end

    assign rom_addr  = cnt;
    assign vga_x     = x0_l + nX'(xoff_d);
    assign vga_y     = y0_l + nY'(yoff_d);
    assign vga_color = erase_l ? bg_color_l : rom_q;

`ifdef OBJECT_DRAW_TRANSPARENT_EN
    assign vga_write = valid_d & (rom_q != n'(TRANSPARENT));
`else
    assign vga_write = valid_d;
`endif

endmodule

// File: tb/tb_object_draw.sv
// tb_object_draw: directed and randomized draws of object_draw against a
// pixel-list reference model built from screen arithmetic.
module tb_object_draw;

    localparam int P = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       erase = 1'b0;
    logic [7:0] x0 = 8'd0;
    logic [6:0] y0 = 7'd0;
    logic [2:0] bg_color = 3'd0;
    logic       busy;
    logic       done;
    logic [5:0] rom_addr;
    logic [2:0] rom_q = 3'd0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_write;

    logic [2:0]  rom [P];
    logic [25:0] got [$];
    int          done_c;
    int          idle_c;
    int          busy1;
    int          errors = 0;
    int          checks = 0;

    object_draw dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .erase     (erase),
        .x0        (x0),
        .y0        (y0),
        .bg_color  (bg_color),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_color (vga_color),
        .vga_write (vga_write)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clock) rom_q <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rom_ramp();
        for (int a = 0; a < P; a++) begin
            logic [5:0] av;
            av = 6'(a);
            rom[a] = av[2:0];
        end
    endtask

    task automatic rom_random();
        for (int a = 0; a < P; a++) rom[a] = 3'($urandom_range(0, 7));
    endtask

    // Start one object and record every write with its cycle offset from
    // the start-sampling edge. Optionally pulse start mid-draw, or apply a
    // reset at the abort_at-th write.
    task automatic run_draw(input logic [7:0] px, input logic [6:0] py,
                            input logic er, input logic [2:0] bg,
                            input int abort_at, input bit mid_start);
        bit stop;
        stop = 1'b0;
        got.delete();
        done_c = -1;
        idle_c = -1;
        busy1  = 0;
        @(negedge clock);
        x0 = px; y0 = py; erase = er; bg_color = bg; start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int c = 1; c <= P + 4 && !stop; c++) begin
            @(negedge clock);
            if (mid_start && c == 10) begin
                start = 1'b1; x0 = ~px; y0 = ~py; erase = ~er;
            end else begin
                start = 1'b0; x0 = px; y0 = py; erase = er;
            end
            if (c == 1) busy1 = int'(busy);
            if (vga_write) begin
                got.push_back({8'(c), vga_x, vga_y, vga_color});
                if (abort_at != 0 && got.size() == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk("abort_write_low", 32'(vga_write), 32'd0);
                    chk("abort_busy_low", 32'(busy), 32'd0);
                    @(posedge clock);
                    @(negedge clock);
                    reset = 1'b0;
                    stop = 1'b1;
                end
            end
            if (done && done_c < 0) done_c = c;
            if (!busy && idle_c < 0) idle_c = c;
        end
        start = 1'b0;
    endtask

    // Compare the recorded writes with the pixel list derived from the
    // object geometry, the ROM image and the mode.
    task automatic check_draw(input string tag, input logic [7:0] px,
                              input logic [6:0] py, input logic er,
                              input logic [2:0] bg);
        logic [25:0] exp_q [$];
        int          nmin;
        for (int yo = 0; yo < 8; yo++) begin
            for (int xo = 0; xo < 8; xo++) begin
                int         a;
                logic [7:0] ex;
                logic [6:0] ey;
                logic [2:0] ec;
                a  = yo * 8 + xo;
                ex = 8'((int'(px) + xo) % 256);
                ey = 7'((int'(py) + yo) % 128);
                ec = er ? bg : rom[a];
`ifdef OBJECT_DRAW_TRANSPARENT_EN
                if (rom[a] != 3'd0) exp_q.push_back({8'(a + 2), ex, ey, ec});
`else
                exp_q.push_back({8'(a + 2), ex, ey, ec});
`endif
            end
        end
        chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        nmin = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) chk({tag, "_pixel"}, 32'(got[i]), 32'(exp_q[i]));
        chk({tag, "_busy_first"}, 32'(busy1), 32'd1);
        chk({tag, "_done_cycle"}, 32'(done_c), 32'(P + 2));
        chk({tag, "_idle_cycle"}, 32'(idle_c), 32'(P + 3));
    endtask

    initial begin
        logic [7:0] rx;
        logic [6:0] ry;
        logic       re;
        logic [2:0] rb;

        // Reset state.
        rom_ramp();
        reset = 1'b1;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_write", 32'(vga_write), 32'd0);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_x", 32'(vga_x), 32'd0);
        chk("rst_y", 32'(vga_y), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Normal draw at (10,20) with a ramp ROM.
        run_draw(8'd10, 7'd20, 1'b0, 3'd0, 0, 1'b0);
        check_draw("normal", 8'd10, 7'd20, 1'b0, 3'd0);
`ifndef OBJECT_DRAW_TRANSPARENT_EN
        chk("normal_first", 32'(got[0]), 32'({8'd2, 8'd10, 7'd20, 3'd0}));
        chk("normal_off9", 32'(got[9]), 32'({8'd11, 8'd11, 7'd21, 3'd1}));
        chk("normal_last", 32'(got[63]), 32'({8'd65, 8'd17, 7'd27, 3'd7}));
`endif

        // Reset while idle after a draw clears the address.
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("idle_rst_addr", 32'(rom_addr), 32'd0);
        chk("idle_rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Erase draw.
        run_draw(8'd10, 7'd20, 1'b1, 3'b001, 0, 1'b0);
        check_draw("erase", 8'd10, 7'd20, 1'b1, 3'b001);

        // Coordinate wrap.
        run_draw(8'd252, 7'd125, 1'b0, 3'd0, 0, 1'b0);
        check_draw("wrap", 8'd252, 7'd125, 1'b0, 3'd0);
`ifndef OBJECT_DRAW_TRANSPARENT_EN
        chk("wrap_off5", 32'(got[5]), 32'({8'd7, 8'd1, 7'd125, 3'd5}));
        chk("wrap_row3", 32'(got[24]), 32'({8'd26, 8'd252, 7'd0, 3'd0}));
`endif

        // Start pulsed during DRAW is ignored.
        run_draw(8'd40, 7'd50, 1'b0, 3'd0, 0, 1'b1);
        check_draw("midstart", 8'd40, 7'd50, 1'b0, 3'd0);

        // Reset at the 30th write, then a fresh draw restarts at offset 0.
        run_draw(8'd60, 7'd30, 1'b0, 3'd0, 30, 1'b0);
        chk("abort_writes", 32'(got.size()), 32'd30);
        run_draw(8'd61, 7'd31, 1'b0, 3'd0, 0, 1'b0);
        check_draw("restart", 8'd61, 7'd31, 1'b0, 3'd0);

        // Randomized objects and ROM images.
        for (int t = 0; t < 6; t++) begin
            rom_random();
            rx = 8'($urandom);
            ry = 7'($urandom);
            re = 1'($urandom);
            rb = 3'($urandom);
            run_draw(rx, ry, re, rb, 0, 1'b0);
            check_draw("random", rx, ry, re, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
